// File: rtl/demux_rr_sched_if.sv
// Handshake and control bundle between the source/consumers and the demux round-robin scheduler.
// The master side drives requests and flow control; the slave side is the scheduler.
interface demux_rr_sched_if;
    logic [3:0] req;
    logic [3:0] dst_ready;
    logic       src_valid;
    logic       src_ready;
    logic [1:0] select;
    logic [3:0] grant;
    logic       busy;
    logic       burst_done;

    modport master (
        output req,
        output dst_ready,
        output src_valid,
        input  src_ready,
        input  select,
        input  grant,
        input  busy,
        input  burst_done
    );

    modport slave (
        input  req,
        input  dst_ready,
        input  src_valid,
        output src_ready,
        output select,
        output grant,
        output busy,
        output burst_done
    );
endinterface

// File: rtl/demux_rr_sched.sv
// Round-robin scheduler for a 1-to-4 demux: arbitrates consumer requests, drives select/grant
// and meters a bounded burst of source beats to the owner before rotating priority.
module demux_rr_sched #(
    parameter int unsigned BURST_LEN = 4
) (
    input logic            clk,
    input logic            rst,
    demux_rr_sched_if.slave bus
);

    localparam logic [7:0] BurstLen = 8'(BURST_LEN);

    typedef enum logic [1:0] {
        StIdle,
        StXfer,
        StDone
    } state_e;

    state_e     state_q, state_d;
    logic [1:0] last_q, last_d;
    logic [1:0] select_q, select_d;
    logic [3:0] grant_q, grant_d;
    logic [7:0] count_q, count_d;
    logic [1:0] pick;
    logic       ready;
    logic       beat;

    // Scan from farthest to nearest so the requester right after last wins.
    function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] l);
        logic [1:0] idx;
        rr_pick = l;
        for (int k = 4; k >= 1; k--) begin
            idx = l + 2'(k);
            if (r[idx]) begin
                rr_pick = idx;
            end
        end
    endfunction

    assign pick  = rr_pick(bus.req, last_q);
    assign ready = (state_q == StXfer) && bus.dst_ready[select_q];
    assign beat  = bus.src_valid && ready;

    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        select_d = select_q;
        grant_d  = grant_q;
        count_d  = count_q;
        unique case (state_q)
            StIdle: begin
                if (|bus.req) begin
                    select_d = pick;
                    grant_d  = 4'b0001 << pick;
                    count_d  = '0;
                    state_d  = StXfer;
                end
            end
            StXfer: begin
                // A beat outranks a dropped request; the request is re-checked next cycle.
                if (beat) begin
                    count_d = count_q + 8'd1;
                    if (count_d == BurstLen) begin
                        state_d = StDone;
                    end
                end else if (!bus.req[select_q]) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                grant_d = '0;
                last_d  = select_q;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            last_q   <= 2'd3;
            select_q <= '0;
            grant_q  <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            select_q <= select_d;
            grant_q  <= grant_d;
            count_q  <= count_d;
        end
    end

    assign bus.src_ready  = ready;
    assign bus.select     = select_q;
    assign bus.grant      = grant_q;
    assign bus.busy       = (state_q != StIdle);
    assign bus.burst_done = (state_q == StDone);

    a_grant_onehot : assert property (@(posedge clk) disable iff (rst) $onehot0(bus.grant));

    a_select_stable : assert property (@(posedge clk) disable iff (rst)
        ($past(|bus.grant) && (|bus.grant)) |-> $stable(bus.select));

    a_count_bound : assert property (@(posedge clk) disable iff (rst) count_q <= BurstLen);

endmodule

// File: tb/tb_demux_rr_sched.sv
// Randomized and directed bench for demux_rr_sched against a cycle-level behavioural model.
module tb_demux_rr_sched;

    localparam int BL = 4;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    demux_rr_sched_if bus ();

    demux_rr_sched #(.BURST_LEN(BL)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: who owns the demux, how many beats delivered, whether in the post-burst cycle.
    int m_owner;
    int m_beats;
    int m_last;
    int m_sel;
    bit m_done;

    logic [3:0] o_grant;
    logic [1:0] o_select;
    logic       o_ready;
    logic       o_busy;
    logic       o_done;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_beats = 0;
        m_last  = 3;
        m_sel   = 0;
        m_done  = 0;
    endtask

    task automatic model_advance(input logic r, input logic [3:0] rq, input logic [3:0] rdy,
                                 input logic v);
        int c;
        if (r) begin
            model_reset();
        end else if (m_owner < 0) begin
            for (int k = 4; k >= 1; k--) begin
                c = (m_last + k) % 4;
                if (rq[c]) begin
                    m_owner = c;
                end
            end
            if (m_owner >= 0) begin
                m_sel   = m_owner;
                m_beats = 0;
            end
        end else if (m_done) begin
            m_last  = m_owner;
            m_owner = -1;
            m_done  = 0;
        end else if (v && rdy[m_owner]) begin
            m_beats++;
            if (m_beats == BL) m_done = 1;
        end else if (!rq[m_owner]) begin
            m_done = 1;
        end
    endtask

    task automatic step(input logic r, input logic [3:0] rq, input logic [3:0] rdy, input logic v);
        logic [3:0] e_grant;
        logic       e_ready;
        @(negedge clk);
        rst           = r;
        bus.req       = rq;
        bus.dst_ready = rdy;
        bus.src_valid = v;
        #1;
        e_grant = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
        e_ready = (m_owner >= 0) && !m_done && rdy[m_owner];
        o_grant  = bus.grant;
        o_select = bus.select;
        o_ready  = bus.src_ready;
        o_busy   = bus.busy;
        o_done   = bus.burst_done;
        check("grant", 32'(o_grant), 32'(e_grant));
        check("select", 32'(o_select), 32'(m_sel));
        check("src_ready", 32'(o_ready), 32'(e_ready));
        check("busy", 32'(o_busy), 32'(m_owner >= 0));
        check("burst_done", 32'(o_done), 32'(m_done));
        model_advance(r, rq, rdy, v);
    endtask

    int pulses;
    int dones;
    int order[$];
    int exp_order[5] = '{0, 1, 2, 3, 0};
    logic [3:0] prev_grant;
    bit seen;

    initial begin
        errors = 0;
        checks = 0;
        rst = 1'b1;
        bus.req = '0;
        bus.dst_ready = '0;
        bus.src_valid = 1'b0;
        model_reset();

        // Reset state
        step(1, 4'b0000, 4'h0, 0);
        step(0, 4'b0000, 4'h0, 0);
        check("rst_grant", 32'(o_grant), 32'd0);
        check("rst_busy", 32'(o_busy), 32'd0);

        // Single full burst to requester 0
        step(0, 4'b0001, 4'hF, 1);
        pulses = 0;
        dones = 0;
        for (int i = 0; i < 7; i++) begin
            step(0, (i < 5) ? 4'b0001 : 4'b0000, 4'hF, 1);
            if (i == 0) check("first_grant", 32'(o_grant), 32'b0001);
            if (i == 5) check("grant_cleared", 32'(o_grant), 32'd0);
            pulses += int'(o_ready);
            dones += int'(o_done);
        end
        check("burst_beats", 32'(pulses), 32'(BL));
        check("burst_done_pulses", 32'(dones), 32'd1);

        // Continuous full pool: rotation 0,1,2,3,0
        step(1, 4'b0000, 4'h0, 0);
        prev_grant = '0;
        order.delete();
        for (int i = 0; i < 40 && order.size() < 5; i++) begin
            step(0, 4'b1111, 4'hF, 1);
            if (prev_grant == 4'b0000 && o_grant != 4'b0000) begin
                for (int b = 0; b < 4; b++) if (o_grant[b]) order.push_back(b);
            end
            prev_grant = o_grant;
        end
        check("rotation_count", 32'(order.size()), 32'd5);
        for (int i = 0; i < 5 && i < order.size(); i++) check("rotation", 32'(order[i]),
                                                              32'(exp_order[i]));

        // Wrap-around scan after serving requester 1
        step(1, 4'b0000, 4'h0, 0);
        seen = 0;
        for (int i = 0; i < 12 && !seen; i++) begin
            step(0, 4'b0010, 4'hF, 1);
            seen = o_done;
        end
        check("wrap_done_seen", 32'(seen), 32'd1);
        step(0, 4'b0011, 4'hF, 0);
        step(0, 4'b0011, 4'hF, 0);
        check("wrap_grant", 32'(o_grant), 32'b0001);

        // Back-pressure mid-burst
        step(1, 4'b0000, 4'h0, 0);
        step(0, 4'b0001, 4'hF, 1);
        pulses = 0;
        for (int i = 0; i < 2; i++) begin
            step(0, 4'b0001, 4'hF, 1);
            pulses += int'(o_ready);
        end
        for (int i = 0; i < 3; i++) begin
            step(0, 4'b0001, 4'h0, 1);
            check("bp_ready_low", 32'(o_ready), 32'd0);
            check("bp_select", 32'(o_select), 32'd0);
        end
        seen = 0;
        for (int i = 0; i < 8 && !seen; i++) begin
            step(0, 4'b0001, 4'hF, 1);
            pulses += int'(o_ready);
            seen = o_done;
        end
        check("bp_beats", 32'(pulses), 32'(BL));

        // Early end: owner drops req with no beat
        step(1, 4'b0000, 4'h0, 0);
        step(0, 4'b0001, 4'hF, 1);
        step(0, 4'b0001, 4'hF, 1);
        step(0, 4'b0001, 4'hF, 1);
        step(0, 4'b0000, 4'hF, 0);
        step(0, 4'b0011, 4'hF, 0);
        check("early_done", 32'(o_done), 32'd1);
        step(0, 4'b0011, 4'hF, 0);
        step(0, 4'b0011, 4'hF, 0);
        check("early_next_grant", 32'(o_grant), 32'b0010);

        // Reset during beat 2
        step(1, 4'b0000, 4'h0, 0);
        step(0, 4'b0001, 4'hF, 1);
        step(0, 4'b0001, 4'hF, 1);
        step(1, 4'b0001, 4'hF, 1);
        check("rst_beat_acked", 32'(o_ready), 32'd1);
        step(0, 4'b1000, 4'hF, 0);
        check("rst_mid_grant", 32'(o_grant), 32'd0);
        check("rst_mid_done", 32'(o_done), 32'd0);
        step(0, 4'b1000, 4'hF, 0);
        check("rst_then_req3", 32'(o_grant), 32'b1000);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 63) == 0), 4'($urandom), 4'($urandom),
                 1'($urandom_range(0, 3) != 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/demux_rr_sched.md
# demux_rr_sched

Round-robin scheduler that sequences the 1-to-4 demultiplexer shared by four downstream consumers. It arbitrates among consumer requests, drives the demux `select` and a one-hot grant, and meters a bounded burst of beats from the single source to the granted output before rotating priority. It sits between the source handshake and the `Demux_1_4` datapath; the demux stays purely combinational.

## Interface
Parameters:
- `BURST_LEN`, default 4: maximum beats per grant, legal range 1..255.

Ports:
- `clk`  input  1  sole clock; all state updates on the rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `req`  input  4  per-consumer request; bit i means output i wants data.
- `dst_ready`  input  4  per-consumer ready; bit i means output i can accept a beat this cycle.
- `src_valid`  input  1  source has a beat on the demux `in` line.
- `src_ready`  output  1  beat accepted this cycle; combinational.
- `select`  output  2  demux select; registered, drives `Demux_1_4` select.
- `grant`  output  4  one-hot current owner; registered; all-zero when nobody owns.
- `busy`  output  1  high in XFER and DONE.
- `burst_done`  output  1  one-cycle pulse in DONE.

## Operation
- FSM states: IDLE, XFER, DONE. Reset state IDLE.
- Priority pointer `last` (2 bits), reset to 3, so requester 0 has first priority after reset.
- IDLE: if `req` is nonzero, pick the first set bit scanning `last+1`, `last+2`, … modulo 4. Load `select` and `grant`, clear the beat counter and go to XFER. If `req` is zero, stay in IDLE.
- XFER:
  - `src_ready = dst_ready[select]`.
  - A beat occurs when `src_valid && src_ready`; the counter increments on each beat.
  - Go to DONE on the beat that makes the count equal `BURST_LEN`.
  - Early end: go to DONE if `req[select]` is 0 in a cycle with no beat. A beat in the same cycle takes precedence: count it, then re-check the request on the next cycle.
- DONE (one cycle):
  - `burst_done` is 1, `grant` is cleared at exit and `last` is loaded with `select`.
  - The next state is always IDLE. There is no back-to-back grant, which guarantees one dead cycle between owners.
- `src_ready` is 0 in IDLE and DONE.
- `select` holds its last value outside XFER and never changes while `grant` is nonzero.
- Counter is 8 bits wide; wrap-around cannot occur because DONE is forced at `BURST_LEN`.
- Requests that change in IDLE only matter on the arbitration edge. Requests from non-owners during XFER are ignored until the next IDLE.

## Timing
- Reset values: `select`=0, `grant`=0, `busy`=0, `burst_done`=0, `src_ready`=0, `last`=3, counter=0, state IDLE.
- Reset asserted mid-XFER aborts the burst at the next edge. Beats offered in that cycle are still combinationally acked.
- Arbitration latency: `req` sampled at edge N in IDLE gives `grant`/`select` valid and `busy`=1 from cycle N+1. The first beat is possible in cycle N+1.
- Full burst: the last beat is in cycle N+BURST_LEN at the earliest, DONE follows in N+BURST_LEN+1, and IDLE in N+BURST_LEN+2.
- Minimum grant period with a continuously requesting pool: BURST_LEN+2 cycles.
- `src_ready` follows `dst_ready` combinationally within the XFER cycle; there is no bubble on back-pressure release.

## Test plan
- Reset then `req`=4'b0001, `src_valid`=1, `dst_ready`=4'hF, BURST_LEN=4 → next cycle `grant`=0001 and `select`=0. Exactly 4 `src_ready` pulses follow, then `burst_done`=1 for 1 cycle, then `grant`=0.
- `req`=4'b1111 held, all ready → grant order 0,1,2,3,0. Each grant lasts 4 cycles, with a 1-cycle DONE and a 1-cycle IDLE gap between grants.
- `last`=1 after serving requester 1, then `req`=4'b0011 → requester 0 is granted, not requester 1 (wrap-around scan 2,3,0).
- Owner `dst_ready` low for 3 cycles mid-burst → `src_ready`=0 and counter frozen. The burst resumes and still delivers exactly 4 beats, and `select` is unchanged throughout.
- Owner drops `req` after 2 beats with `src_valid`=0 → DONE next cycle and `burst_done` pulses. Next arbitration starts from `last`=owner.
- `rst`=1 during beat 2 of a burst → next cycle all outputs are at reset values and `last`=3. A subsequent `req`=4'b1000 is granted to requester 3.
